// File: rtl/lwe_decrypt.sv
// Serial LWE decryption: pt = round((b - <a,s>) mod q / delta) mod t; result 1 cycle after b, held until pt_ready.
// ct_ready drops while a result waits; optional noise_flag via LWE_DECRYPT_NOISE_CHECK_EN.
module lwe_decrypt #(
  parameter int unsigned PLAINTEXT_MODULUS  = 64,
  parameter int unsigned PLAINTEXT_WIDTH    = 6,
  parameter int unsigned CIPHERTEXT_MODULUS = 1024,
  parameter int unsigned CIPHERTEXT_WIDTH   = 10,
  parameter int unsigned DIMENSION          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ct_valid,
  output logic                        ct_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_a,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_s,
  output logic                        pt_valid,
  input  logic                        pt_ready,
`ifdef LWE_DECRYPT_NOISE_CHECK_EN
  output logic                        noise_flag,
`endif
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext
);

  localparam int unsigned CW    = CIPHERTEXT_WIDTH;
  localparam int unsigned DELTA = CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS;
  localparam int unsigned LD    = $clog2(DELTA);
  localparam int unsigned IW    = (DIMENSION < 1) ? 1 : $clog2(DIMENSION + 1);

  typedef enum logic {ACCUM, OUT} state_t;

  state_t        state;
  logic [CW-1:0] acc;
  logic [CW-1:0] diff;
  logic [IW-1:0] idx;
  logic [CW-1:0] prod_lo;
  logic [CW-1:0] rounded;
  logic          accept;

  // Full 2*CW-bit product; only the residue mod q is accumulated.
  assign prod_lo = CW'({{CW{1'b0}}, ct_a} * {{CW{1'b0}}, ct_s});
  assign accept  = ct_valid && (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      idx   <= '0;
      diff  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (idx == IW'(DIMENSION)) begin
              diff  <= ct_a - acc;
              state <= OUT;
            end else begin
              acc <= acc + prod_lo;
              idx <= idx + 1'b1;
            end
          end
        end
        OUT: begin
          if (pt_ready) begin
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign ct_ready = (state == ACCUM);
  assign pt_valid = (state == OUT);

  // Adding delta/2 before the shift rounds to nearest; wrap past q maps to 0.
  assign rounded   = diff + CW'(DELTA / 2);
  assign plaintext = PLAINTEXT_WIDTH'(rounded >> LD);

`ifdef LWE_DECRYPT_NOISE_CHECK_EN
  // Residue in [delta/4, 3*delta/4) sits near the decision boundary.
  assign noise_flag = pt_valid && (diff[LD-1] ^ diff[LD-2]);
`endif

endmodule
